timer_countdown: RTL
====================

Name: timer_countdown

Overview:
- Consumes the three BCD digits (M:ST) produced by the keypad timer-input stage and counts them down to 0:00 at a 1 Hz rate derived from clk.
- Implements the microwave run/pause/clear control and drives the heater enable and done indication.
- Current digits are output every cycle for the 7-segment display driver.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per one-second tick; minimum 2.
- DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= CLK_DIV.
- BEEP_TICKS, 3, seconds the beep output stays high after completion; used only with TIMER_BEEP_EN.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous, active-high reset.
- in_units_sec, input, 4, BCD seconds-units digit from timer input.
- in_tens_sec, input, 4, BCD seconds-tens digit from timer input.
- in_units_min, input, 4, BCD minutes digit from timer input.
- start, input, 1, level; start or resume cooking.
- pause, input, 1, level; pause cooking.
- clear, input, 1, level; abort and return to IDLE.
- door_closed, input, 1, 1 = door closed.
- units_sec, output, 4, current seconds-units digit.
- tens_sec, output, 4, current seconds-tens digit.
- units_min, output, 4, current minutes digit.
- heater_on, output, 1, high only in RUNNING.
- done, output, 1, one-cycle pulse when 0:00 is reached.
- state_out, output, 2, current FSM state.

Behaviour:
- Reset (asynchronous):
  - State = IDLE.
  - All digits = 0; prescaler = 0.
  - heater_on = 0, done = 0.
- States and encoding: IDLE = 0, RUNNING = 1, PAUSED = 2, DONE = 3.
- Event priority each cycle: clear > !door_closed > pause > start.
- IDLE:
  - Digit registers load the input digits every clk.
  - Any input digit > 9 (including the 4'hF idle code) loads as 9.
  - start && door_closed with loaded value non-zero → RUNNING and prescaler := 0.
  - start with value 0:00 is ignored and the state stays IDLE.
- RUNNING:
  - Prescaler increments each clk.
  - When prescaler == CLK_DIV-1, it wraps to 0 and the value decrements by one second.
  - First decrement occurs exactly CLK_DIV cycles after the cycle that entered RUNNING.
  - !door_closed or pause → PAUSED. The prescaler holds its count; no decrement happens in that cycle.
- Decrement rules (BCD, borrow chain):
  - units_sec 0 → 9, with a borrow into tens_sec.
  - tens_sec 0 → 5, with a borrow into units_min.
  - Loaded tens_sec values 6..9 count down normally. Example: 1:90 runs 150 s.
- Reaching 0:00: the decrement that produces 0:00 also moves the FSM to DONE, drives done = 1 for that next cycle only, and drops heater_on in the same cycle.
- PAUSED:
  - Digits and prescaler are frozen.
  - start && door_closed && !pause → RUNNING, resuming from the held prescaler value.
  - Input digits are ignored.
- DONE:
  - Digits read 0:00.
  - clear or start → IDLE; the IDLE digit-load rule applies from the following cycle.
- clear in any state (even the same cycle as a tick) → IDLE with prescaler = 0; no done pulse.
- heater_on is a registered output: 1 iff the next state is RUNNING.
- Reset mid-run: the asynchronous reset returns all outputs to reset values immediately.

Optional Feature:
- TIMER_BEEP_EN:
  - When defined, adds output beep (1 bit). beep rises with done and stays high for BEEP_TICKS one-second ticks. The prescaler keeps running in DONE while beep is active.
  - beep is cleared by clear, start, or reset.
- Without the macro: no beep port, and the prescaler is idle outside RUNNING.

Decomposition:
- Shared include timer_defs.vh:
  - State encodings (ST_IDLE, ST_RUNNING, ST_PAUSED, ST_DONE).
  - Digit limits DIGIT_MAX = 9 and TENS_SEC_MAX = 5.
- Sub-module bcd_digit_down:
  - Parameter WRAP (reload value).
  - Inputs: digit, dec_en.
  - Outputs: next_digit, borrow_out.
  - Instantiated three times (WRAP 9, 5, 9); the minutes instance's borrow is unused.
- FSM and prescaler stay in timer_countdown.

Test Plan:
1. CLK_DIV=4, inputs 0:0:3, start:
   - Digits read 0:02, 0:01, 0:00 at cycles 4, 8, 12 after entering RUNNING.
   - done is high for 1 cycle, then the state is DONE and heater_on = 0.
2. Load 1:00, run one tick → 0:59 (borrow across both digits). Load 0:10, run one tick → 0:09.
3. Inputs F:F:F → digits read 9:9:9. Load 0:0:0 and assert start → the state stays IDLE.
4. Run 0:05 with CLK_DIV=4:
   - Drop door_closed at prescaler = 2 → PAUSED, heater_on = 0, digits frozen for 20 cycles.
   - Restore the door and pulse start → the next decrement occurs 2 cycles later.
5. pause and start asserted together in RUNNING → PAUSED. clear on the same cycle as a tick at 0:01 → IDLE, no done pulse.
6. Assert rst asynchronously mid-run → all digits 0, state IDLE, heater_on = 0 before the next clk edge.

Source files
------------

// File: rtl/timer_countdown_pkg.sv
// Shared state encoding, BCD digit limits and input clamping for the microwave countdown timer.
package timer_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] TENS_SEC_MAX = 4'd5;

    // Non-BCD codes, including the keypad's 4'hF idle code, load as 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: decrements on dec_en, reloads WRAP and borrows at zero.
module bcd_digit_down
    import timer_countdown_pkg::*;
#(
    parameter logic [3:0] WRAP = DIGIT_MAX
) (
    input  logic [3:0] digit,
    input  logic       dec_en,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_digit = digit;
        borrow_out = 1'b0;
        if (dec_en) begin
            if (digit == 4'd0) begin
                next_digit = WRAP;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_countdown.sv
// Microwave run/pause/clear controller counting M:ST BCD digits down to 0:00 at one tick per CLK_DIV clocks.
// Define TIMER_BEEP_EN to add the beep output held for BEEP_TICKS seconds after completion.
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int DIV_W   = 26
`ifdef TIMER_BEEP_EN
    ,
    parameter int BEEP_TICKS = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_units_sec,
    input  logic [3:0] in_tens_sec,
    input  logic [3:0] in_units_min,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       door_closed,
    output logic [3:0] units_sec,
    output logic [3:0] tens_sec,
    output logic [3:0] units_min,
    output logic       heater_on,
    output logic       done,
    output logic [1:0] state_out
`ifdef TIMER_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       us_q, us_d, ts_q, ts_d, um_q, um_d;
    logic             heater_q, done_q, done_d;

    logic [3:0] in_us, in_ts, in_um;
    logic       in_nonzero, tick, run_tick, reach_zero;
    logic [3:0] us_dec, ts_dec, um_dec;
    logic       us_borrow, ts_borrow, min_borrow_unused;

    assign in_us      = clamp_digit(in_units_sec);
    assign in_ts      = clamp_digit(in_tens_sec);
    assign in_um      = clamp_digit(in_units_min);
    assign in_nonzero = ((in_us | in_ts | in_um) != 4'd0);
    assign tick       = (presc_q == PRESC_LAST);

    // A second elapses only while running and not pre-empted by a higher-priority event.
    assign run_tick = (state_q == ST_RUNNING) && !clear && door_closed && !pause && tick;

    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_units_sec (
        .digit(us_q), .dec_en(run_tick), .next_digit(us_dec), .borrow_out(us_borrow)
    );
    bcd_digit_down #(.WRAP(TENS_SEC_MAX)) u_tens_sec (
        .digit(ts_q), .dec_en(us_borrow), .next_digit(ts_dec), .borrow_out(ts_borrow)
    );
    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_units_min (
        .digit(um_q), .dec_en(ts_borrow), .next_digit(um_dec), .borrow_out(min_borrow_unused)
    );

    assign reach_zero = ({um_dec, ts_dec, us_dec} == 12'd0);

`ifdef TIMER_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_TICKS + 1);

    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
    logic              beep_active;

    assign beep_active = (beep_cnt_q != '0);
    assign beep        = beep_active;

    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (done_d) begin
            beep_cnt_d = BEEP_W'(BEEP_TICKS);
        end else if (clear || start) begin
            beep_cnt_d = '0;
        end else if ((state_q == ST_DONE) && tick && beep_active) begin
            beep_cnt_d = beep_cnt_q - BEEP_W'(1);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        us_d    = us_q;
        ts_d    = ts_q;
        um_d    = um_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                us_d    = in_us;
                ts_d    = in_ts;
                um_d    = in_um;
                presc_d = '0;
                if (!clear && door_closed && !pause && start && in_nonzero) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (!door_closed || pause) begin
                    state_d = ST_PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    us_d    = us_dec;
                    ts_d    = ts_dec;
                    um_d    = um_dec;
                    if (reach_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            ST_PAUSED: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (door_closed && !pause && start) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_DONE: begin
                us_d = 4'd0;
                ts_d = 4'd0;
                um_d = 4'd0;
                if (clear || start) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
`ifdef TIMER_BEEP_EN
                else if (beep_active) begin
                    presc_d = tick ? '0 : presc_q + DIV_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            us_q       <= 4'd0;
            ts_q       <= 4'd0;
            um_q       <= 4'd0;
            heater_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef TIMER_BEEP_EN
            beep_cnt_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge next-state values.
            state_q    <= state_d;
            presc_q    <= presc_d;
            us_q       <= us_d;
            ts_q       <= ts_d;
            um_q       <= um_d;
            heater_q   <= (state_d == ST_RUNNING);
            done_q     <= done_d;
`ifdef TIMER_BEEP_EN
            beep_cnt_q <= beep_cnt_d;
`endif
        end
    end

    assign units_sec = us_q;
    assign tens_sec  = ts_q;
    assign units_min = um_q;
    assign heater_on = heater_q;
    assign done      = done_q;
    assign state_out = state_q;

endmodule
